// File: rtl/dsp_mac_seq_if.sv
// Bundles the control, sample stream, result and DSP-slice signals of dsp_mac_seq.
// slave is the sequencer's view; master is the view of whoever drives it (and models the DSP).
interface dsp_mac_seq_if #(
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [17:0]      s_a;
    logic signed [17:0]      s_b;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [47:0]      res_data;
    logic                    busy;
    logic                    len_err;
    logic signed [17:0]      dsp_a;
    logic signed [17:0]      dsp_b;
    logic [7:0]              dsp_opmode;
    logic                    dsp_ce;
    logic signed [47:0]      dsp_p;

    modport slave (
        input  start, len, s_valid, s_a, s_b, res_ready, dsp_p,
        output s_ready, res_valid, res_data, busy, len_err,
               dsp_a, dsp_b, dsp_opmode, dsp_ce
    );

    modport master (
        output start, len, s_valid, s_a, s_b, res_ready, dsp_p,
        input  s_ready, res_valid, res_data, busy, len_err,
               dsp_a, dsp_b, dsp_opmode, dsp_ce
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// Sequences an external DSP slice through a len-sample dot product; result valid DSP_LAT cycles after the last sample.
// Backpressure: s_ready only in STREAM, DSP pipeline frozen on idle stream cycles; result held in DONE until res_ready.
module dsp_mac_seq #(
    parameter int DSP_LAT = 4,
    parameter int LEN_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dsp_mac_seq_if.slave  io
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam int         DW      = $clog2(DSP_LAT + 1);
    localparam logic [7:0] OP_LOAD = 8'b0000_0001;
    localparam logic [7:0] OP_ACC  = 8'b0000_1001;
    localparam logic [7:0] OP_HOLD = 8'b0000_1000;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      drn_q, drn_d;
    logic               first_q, first_d;
    logic [47:0]        res_data_q, res_data_d;
    logic               len_err_q, len_err_d;

    logic s_hs;
    logic r_hs;
    logic last_pair;
    logic drn_last;

    assign s_hs      = (state_q == STREAM) && io.s_valid;
    assign r_hs      = (state_q == DONE) && io.res_ready;
    assign last_pair = (cnt_q == LEN_W'(1));
    assign drn_last  = (drn_q == DW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.start && (io.len != '0)) state_d = STREAM;
            STREAM:  if (s_hs && last_pair)          state_d = DRAIN;
            DRAIN:   if (drn_last)                   state_d = DONE;
            DONE:    if (r_hs)                       state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            drn_q      <= '0;
            first_q    <= 1'b0;
            res_data_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            drn_q      <= drn_d;
            first_q    <= first_d;
            res_data_q <= res_data_d;
            len_err_q  <= len_err_d;
        end
    end

    // first_q selects the accumulator-clearing opmode, so a stale P never leaks into a new job.
    always_comb begin
        cnt_d      = cnt_q;
        drn_d      = drn_q;
        first_d    = first_q;
        res_data_d = res_data_q;
        len_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    if (io.len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        cnt_d   = io.len;
                        first_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (s_hs) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    first_d = 1'b0;
                    if (last_pair) drn_d = DW'(DSP_LAT);
                end
            end
            DRAIN: begin
                drn_d = drn_q - DW'(1);
                if (drn_last) res_data_d = io.dsp_p;
            end
            default: ;
        endcase
    end

    always_comb begin
        io.s_ready    = 1'b0;
        io.dsp_a      = '0;
        io.dsp_b      = '0;
        io.dsp_opmode = '0;
        io.dsp_ce     = 1'b0;
        case (state_q)
            STREAM: begin
                io.s_ready = 1'b1;
                if (s_hs) begin
                    io.dsp_a      = io.s_a;
                    io.dsp_b      = io.s_b;
                    io.dsp_opmode = first_q ? OP_LOAD : OP_ACC;
                    io.dsp_ce     = 1'b1;
                end
            end
            DRAIN: begin
                io.dsp_opmode = OP_HOLD;
                io.dsp_ce     = 1'b1;
            end
            default: ;
        endcase
    end

    assign io.busy      = (state_q != IDLE);
    assign io.res_valid = (state_q == DONE);
    assign io.res_data  = res_data_q;
    assign io.len_err   = len_err_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP slice (DSP_LAT clock-enabled stages ending in the P register).
module tb_dsp_mac_seq;
    localparam int DSP_LAT = 4;
    localparam int LEN_W   = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dsp_mac_seq_if #(.LEN_W(LEN_W)) io ();

    dsp_mac_seq #(.DSP_LAT(DSP_LAT), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DSP model: DSP_LAT-1 product stages then P; the slice itself is not reset, so stale contents persist.
    logic signed [35:0] m_pipe  [0:DSP_LAT-2];
    logic [7:0]         op_pipe [0:DSP_LAT-2];
    logic signed [47:0] p_reg;

    initial begin
        for (int i = 0; i < DSP_LAT - 1; i++) begin
            m_pipe[i]  = 36'sd77;
            op_pipe[i] = 8'h09;
        end
        p_reg = 48'sh0000_DEAD_BEEF;
    end

    always @(posedge clk) begin
        if (io.dsp_ce) begin
            m_pipe[0]  <= io.dsp_a * io.dsp_b;
            op_pipe[0] <= io.dsp_opmode;
            for (int i = 1; i < DSP_LAT - 1; i++) begin
                m_pipe[i]  <= m_pipe[i-1];
                op_pipe[i] <= op_pipe[i-1];
            end
            case (op_pipe[DSP_LAT-2])
                8'h01:   p_reg <= {{12{m_pipe[DSP_LAT-2][35]}}, m_pipe[DSP_LAT-2]};
                8'h09:   p_reg <= p_reg + {{12{m_pipe[DSP_LAT-2][35]}}, m_pipe[DSP_LAT-2]};
                default: p_reg <= p_reg;
            endcase
        end
    end

    assign io.dsp_p = p_reg;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [LEN_W-1:0] l);
        io.start = 1'b1;
        io.len   = l;
        tick();
        io.start = 1'b0;
        io.len   = '0;
    endtask

    task automatic send_pair(input logic signed [17:0] a, input logic signed [17:0] b,
                             output logic [7:0] op, output logic ce, output logic signed [17:0] da);
        io.s_valid = 1'b1;
        io.s_a     = a;
        io.s_b     = b;
        #1;
        op = io.dsp_opmode;
        ce = io.dsp_ce;
        da = io.dsp_a;
        tick();
        io.s_valid = 1'b0;
        io.s_a     = '0;
        io.s_b     = '0;
    endtask

    // cyc counts falling edges since the final handshake, starting at 1 for the first one after it.
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (io.res_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume;
        io.res_ready = 1'b1;
        tick();
        io.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (io.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", io.busy); end
        checks++; if (io.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %0b want 0", io.s_ready); end
        checks++; if (io.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %0b want 0", io.res_valid); end
        checks++; if (io.res_data !== 48'sd0) begin failures++; $display("FAIL reset_res_data: got %0d want 0", io.res_data); end
        checks++; if (io.dsp_ce !== 1'b0 || io.dsp_opmode !== 8'h00) begin failures++; $display("FAIL reset_dsp: ce=%0b op=%h want 0/00", io.dsp_ce, io.dsp_opmode); end
        checks++; if (io.len_err !== 1'b0) begin failures++; $display("FAIL reset_len_err: got %0b want 0", io.len_err); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] op; logic ce; logic signed [17:0] da; int cyc;
        do_start(8'd3);
        send_pair(18'sd5, 18'sd6, op, ce, da);
        checks++; if (op !== 8'h01 || ce !== 1'b1 || da !== 18'sd5) begin failures++; $display("FAIL b2b_pair1: op=%h ce=%0b a=%0d want 01/1/5", op, ce, da); end
        send_pair(18'sd2, 18'sd20, op, ce, da);
        checks++; if (op !== 8'h09 || ce !== 1'b1) begin failures++; $display("FAIL b2b_pair2: op=%h ce=%0b want 09/1", op, ce); end
        send_pair(-18'sd3, 18'sd4, op, ce, da);
        checks++; if (op !== 8'h09 || da !== -18'sd3) begin failures++; $display("FAIL b2b_pair3: op=%h a=%0d want 09/-3", op, da); end
        #1;
        checks++; if (io.dsp_ce !== 1'b1 || io.dsp_opmode !== 8'h08) begin failures++; $display("FAIL b2b_drain_ctl: ce=%0b op=%h want 1/08", io.dsp_ce, io.dsp_opmode); end
        checks++; if (io.s_ready !== 1'b0 || io.dsp_a !== 18'sd0 || io.busy !== 1'b1) begin failures++; $display("FAIL b2b_drain_io: s_ready=%0b a=%0d busy=%0b want 0/0/1", io.s_ready, io.dsp_a, io.busy); end
        wait_result(cyc);
        checks++; if (cyc !== DSP_LAT + 1) begin failures++; $display("FAIL b2b_latency: got %0d want %0d", cyc, DSP_LAT + 1); end
        checks++; if (io.res_data !== 48'sd58) begin failures++; $display("FAIL b2b_data: got %0d want 58", io.res_data); end
        checks++; if (io.dsp_ce !== 1'b0 || io.dsp_opmode !== 8'h00) begin failures++; $display("FAIL b2b_done_dsp: ce=%0b op=%h want 0/00", io.dsp_ce, io.dsp_opmode); end
        consume();
        checks++; if (io.busy !== 1'b0 || io.res_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy=%0b res_valid=%0b want 0/0", io.busy, io.res_valid); end
    endtask

    task automatic test_stall;
        logic [7:0] op; logic ce; logic signed [17:0] da; int cyc;
        do_start(8'd2);
        send_pair(18'sd7, 18'sd7, op, ce, da);
        checks++; if (op !== 8'h01 || ce !== 1'b1) begin failures++; $display("FAIL stall_pair1: op=%h ce=%0b want 01/1", op, ce); end
        for (int g = 0; g < 3; g++) begin
            #1;
            checks++; if (io.dsp_ce !== 1'b0 || io.s_ready !== 1'b1) begin failures++; $display("FAIL stall_gap%0d: ce=%0b s_ready=%0b want 0/1", g, io.dsp_ce, io.s_ready); end
            tick();
        end
        send_pair(18'sd1, 18'sd1, op, ce, da);
        checks++; if (op !== 8'h09 || ce !== 1'b1) begin failures++; $display("FAIL stall_pair2: op=%h ce=%0b want 09/1", op, ce); end
        wait_result(cyc);
        checks++; if (cyc !== DSP_LAT + 1) begin failures++; $display("FAIL stall_latency: got %0d want %0d", cyc, DSP_LAT + 1); end
        checks++; if (io.res_data !== 48'sd50) begin failures++; $display("FAIL stall_data: got %0d want 50", io.res_data); end
        consume();
    endtask

    task automatic test_len_zero;
        io.start = 1'b1;
        io.len   = '0;
        #1;
        checks++; if (io.len_err !== 1'b0) begin failures++; $display("FAIL lenz_pre: len_err=%0b want 0", io.len_err); end
        tick();
        io.start = 1'b0;
        checks++; if (io.len_err !== 1'b1) begin failures++; $display("FAIL lenz_pulse: len_err=%0b want 1", io.len_err); end
        checks++; if (io.busy !== 1'b0 || io.s_ready !== 1'b0) begin failures++; $display("FAIL lenz_idle: busy=%0b s_ready=%0b want 0/0", io.busy, io.s_ready); end
        tick();
        checks++; if (io.len_err !== 1'b0) begin failures++; $display("FAIL lenz_end: len_err=%0b want 0", io.len_err); end
        checks++; if (io.busy !== 1'b0 || io.s_ready !== 1'b0) begin failures++; $display("FAIL lenz_after: busy=%0b s_ready=%0b want 0/0", io.busy, io.s_ready); end
    endtask

    task automatic test_hold;
        logic [7:0] op; logic ce; logic signed [17:0] da; int cyc;
        do_start(8'd1);
        send_pair(-18'sd131072, -18'sd131072, op, ce, da);
        checks++; if (op !== 8'h01 || da !== -18'sd131072) begin failures++; $display("FAIL hold_pair: op=%h a=%0d want 01/-131072", op, da); end
        wait_result(cyc);
        checks++; if (cyc !== DSP_LAT + 1) begin failures++; $display("FAIL hold_latency: got %0d want %0d", cyc, DSP_LAT + 1); end
        for (int k = 0; k < 5; k++) begin
            io.start = (k == 2);
            io.len   = 8'd2;
            #1;
            checks++; if (io.res_valid !== 1'b1 || io.res_data !== 48'sd17179869184) begin failures++; $display("FAIL hold_c%0d: res_valid=%0b data=%0d want 1/17179869184", k, io.res_valid, io.res_data); end
            tick();
        end
        io.start = 1'b0;
        io.len   = '0;
        checks++; if (io.res_valid !== 1'b1 || io.s_ready !== 1'b0) begin failures++; $display("FAIL hold_start_ignored: res_valid=%0b s_ready=%0b want 1/0", io.res_valid, io.s_ready); end
        consume();
        checks++; if (io.busy !== 1'b0 || io.s_ready !== 1'b0) begin failures++; $display("FAIL hold_idle: busy=%0b s_ready=%0b want 0/0", io.busy, io.s_ready); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] op; logic ce; logic signed [17:0] da; int cyc;
        do_start(8'd4);
        send_pair(18'sd11, 18'sd13, op, ce, da);
        send_pair(18'sd17, 18'sd19, op, ce, da);
        checks++; if (io.busy !== 1'b1 || io.s_ready !== 1'b1) begin failures++; $display("FAIL rmid_pre: busy=%0b s_ready=%0b want 1/1", io.busy, io.s_ready); end
        #2;
        io.s_valid = 1'b1;
        io.s_a     = 18'sd9;
        io.s_b     = 18'sd9;
        rst_n      = 1'b0;
        #1;
        checks++; if (io.busy !== 1'b0 || io.s_ready !== 1'b0) begin failures++; $display("FAIL rmid_ctl: busy=%0b s_ready=%0b want 0/0", io.busy, io.s_ready); end
        checks++; if (io.dsp_ce !== 1'b0 || io.dsp_a !== 18'sd0 || io.dsp_b !== 18'sd0 || io.dsp_opmode !== 8'h00) begin failures++; $display("FAIL rmid_dsp: ce=%0b a=%0d b=%0d op=%h want 0/0/0/00", io.dsp_ce, io.dsp_a, io.dsp_b, io.dsp_opmode); end
        checks++; if (io.res_valid !== 1'b0 || io.res_data !== 48'sd0 || io.len_err !== 1'b0) begin failures++; $display("FAIL rmid_res: res_valid=%0b data=%0d len_err=%0b want 0/0/0", io.res_valid, io.res_data, io.len_err); end
        tick();
        io.s_valid = 1'b0;
        io.s_a     = '0;
        io.s_b     = '0;
        rst_n      = 1'b1;
        tick();
        do_start(8'd1);
        send_pair(18'sd3, 18'sd3, op, ce, da);
        checks++; if (op !== 8'h01 || ce !== 1'b1) begin failures++; $display("FAIL rmid_first_op: op=%h ce=%0b want 01/1", op, ce); end
        wait_result(cyc);
        checks++; if (cyc !== DSP_LAT + 1) begin failures++; $display("FAIL rmid_latency: got %0d want %0d", cyc, DSP_LAT + 1); end
        checks++; if (io.res_data !== 48'sd9) begin failures++; $display("FAIL rmid_data: got %0d want 9", io.res_data); end
        consume();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        io.start     = 1'b0;
        io.len       = '0;
        io.s_valid   = 1'b0;
        io.s_a       = '0;
        io.s_b       = '0;
        io.res_ready = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_stall();
        test_len_zero();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
